// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the serial pattern detector: accepts WIDTH-bit
// words over valid/ready and emits one bit per bit_en cycle, back-to-back without gaps.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             out,
  output logic             out_valid,
  output logic             sof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next, shifted;
  logic [CW-1:0]    count_reg, count_next;
  logic             last_bit, accept;

  // Shift one position toward the output end, filling with zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign out       = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
  assign busy      = (state_reg == SHIFT);
  assign out_valid = busy;
  assign sof       = busy && (count_reg == '0);
  assign last_bit  = busy && bit_en && (count_reg == LAST);
  assign in_ready  = !busy || last_bit;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    count_next = count_reg;
    if (accept) begin
      state_next = SHIFT;
      shreg_next = in_data;
      count_next = '0;
    end else if (last_bit) begin
      // Clearing the register keeps out at 0 while idle.
      state_next = IDLE;
      shreg_next = '0;
      count_next = '0;
    end else if (busy && bit_en) begin
      shreg_next = shifted;
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: one MSB-first and one LSB-first instance, a bit-level
// scoreboard filled on every accept, plus vector table and multi-cycle sequences.
module tb_bit_serializer;

  typedef struct {
    int         d;
    logic       b;
    logic       first;
  } exp_t;

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [7:0] ser;   // expected emission order, ser[7] leaves first
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            bit_en;
  logic [1:0]      iv, ir, ov, o, sf, bz;
  logic [1:0][7:0] din;

  exp_t       sbq[$];
  logic [7:0] drv_ser;
  logic       acc;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .bit_en(bit_en), .out(o[0]), .out_valid(ov[0]), .sof(sf[0]), .busy(bz[0]));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .bit_en(bit_en), .out(o[1]), .out_valid(ov[1]), .sof(sf[1]), .busy(bz[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: consume bits the detector would sample, record accepts, land at posedge+1.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset && ov[d] && bit_en) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("bit_dut", d, e.d);
          chk("bit_out", o[d], e.b);
          chk("bit_sof", sf[d], e.first);
          $display("dut%0d bit out=%0b sof=%0b", d, o[d], sf[d]);
        end
      end
      if (reset && iv[d] && ir[d]) begin
        acc = 1'b1;
        for (int i = 7; i >= 0; i--) sbq.push_back(exp_t'{d, drv_ser[i], (i == 7)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic [7:0] ser, output int waited);
    waited  = 0;
    acc     = 1'b0;
    drv_ser = ser;
    din[d]  = data;
    iv[d]   = 1'b1;
    while (!acc && waited < 64) begin
      cyc();
      if (!acc) waited++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    iv[d] = 1'b0;
    $display("dut%0d word %02h accepted after %0d stall cycles", d, data, waited);
  endtask

  // Expect n contiguous valid cycles starting now, then idle and ready.
  task automatic run(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      chk("run_valid", ov[d], 1'b1);
      chk("run_sof", sf[d], (i == 0));
      cyc();
    end
    chk("run_idle_valid", ov[d], 1'b0);
    chk("run_idle_ready", ir[d], 1'b1);
    chk("run_idle_out", o[d], 1'b0);
  endtask

  vec_t tbl[9];
  int   w;

  initial begin
    tbl[0] = '{0, 8'hAC, 8'b10101100};
    tbl[1] = '{1, 8'h35, 8'b10101100};
    tbl[2] = '{0, 8'h5A, 8'b01011010};
    tbl[3] = '{1, 8'h5A, 8'b01011010};
    tbl[4] = '{0, 8'h81, 8'b10000001};
    tbl[5] = '{1, 8'h0E, 8'b01110000};
    tbl[6] = '{1, 8'h80, 8'b00000001};
    tbl[7] = '{0, 8'h00, 8'b00000000};
    tbl[8] = '{0, 8'hFF, 8'b11111111};

    reset = 1'b0; iv = '0; din = '0; bit_en = 1'b1; acc = 1'b0; drv_ser = '0;
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      chk("rst_out", o[d], 1'b0);
      chk("rst_valid", ov[d], 1'b0);
      chk("rst_ready", ir[d], 1'b1);
      chk("rst_busy", bz[d], 1'b0);
      chk("rst_sof", sf[d], 1'b0);
    end
    reset = 1'b1;

    // Single word right after release.
    send(0, 8'hAC, 8'b10101100, w);
    chk("t1_wait", w, 0);
    run(0, 8);

    // Back-to-back: second word only taken in the last-bit cycle, no gap.
    send(0, 8'hAC, 8'b10101100, w);
    send(0, 8'h5A, 8'b01011010, w);
    chk("t2_wait", w, 7);
    run(0, 8);

    // Pacing: each bit held two cycles, word spans 16 cycles.
    send(0, 8'hF0, 8'b11110000, w);
    for (int i = 1; i <= 16; i++) begin
      bit_en = (i % 2 == 0);
      chk("t3_valid", ov[0], 1'b1);
      chk("t3_out", o[0], (i <= 8));
      chk("t3_sof", sf[0], (i <= 2));
      cyc();
    end
    bit_en = 1'b1;
    chk("t3_done", ov[0], 1'b0);

    // Handshake stall while busy.
    send(0, 8'hFF, 8'b11111111, w);
    cyc();
    cyc();
    chk("t4_ready_busy", ir[0], 1'b0);
    send(0, 8'h81, 8'b10000001, w);
    chk("t4_wait", w, 5);
    run(0, 8);

    // Vector table, both bit orders.
    foreach (tbl[k]) begin
      send(tbl[k].d, tbl[k].data, tbl[k].ser, w);
      chk("tbl_wait", w, 0);
      run(tbl[k].d, 8);
    end

    // Reset mid-word: remaining bits must never appear.
    send(0, 8'hFF, 8'b11111111, w);
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("t6_valid", ov[0], 1'b0);
    chk("t6_out", o[0], 1'b0);
    chk("t6_busy", bz[0], 1'b0);
    sbq.delete();
    cyc();
    cyc();
    reset = 1'b1;
    chk("t6_ready", ir[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_quiet", ov[0], 1'b0);
      cyc();
    end
    send(0, 8'hAC, 8'b10101100, w);
    chk("t6_wait", w, 0);
    run(0, 8);

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
